// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and buffers returned words with their PCs for the datapath.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_FETCH | no request outstanding; issue one if a FIFO slot is free
//   ST_WAIT  | one request outstanding; its response will be pushed
//   ST_DROP  | one stale request outstanding; its response will be dropped
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruccion_r,
    output logic [31:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [31:0]     pc_mem_q [DEPTH];
    logic [31:0]     pc_mem_d [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic [31:0]     redirect_pc_al;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        issue    = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc_al;
                end else if (count_q < DEPTH_C) begin
                    issue    = 1'b1;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc_al;
                    state_d = imem_rvalid ? ST_FETCH : ST_DROP;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                // Redirects here only retarget the PC; the FIFO is already empty.
                if (redirect_valid) pc_d = redirect_pc_al;
                if (imem_rvalid) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pop         = (count_q != '0) && instr_ready && !flush;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = imem_rdata;
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    // Gated by rst_n so no request escapes while reset is held.
    assign imem_req      = issue & rst_n;
    assign imem_addr     = pc_q;
    assign instr_valid   = (count_q != '0);
    assign instruccion_r = instr_mem_q[rd_ptr_q];
    assign instr_pc      = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: DUT a uses default parameters, DUT b uses a
// wrapping reset PC with a deeper FIFO.
module tb_fetch_stage;

    logic        clk;
    int          n_tests;
    int          n_fail;

    logic        a_rst_n, a_req, a_rv, a_redir, a_valid, a_rdy;
    logic [31:0] a_addr, a_rd, a_rpc, a_instr, a_pc;
    logic        b_rst_n, b_req, b_rv, b_redir, b_valid, b_rdy;
    logic [31:0] b_addr, b_rd, b_rpc, b_instr, b_pc;

    fetch_stage u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .imem_req(a_req), .imem_addr(a_addr),
        .imem_rvalid(a_rv), .imem_rdata(a_rd),
        .redirect_valid(a_redir), .redirect_pc(a_rpc),
        .instr_valid(a_valid), .instr_ready(a_rdy),
        .instruccion_r(a_instr), .instr_pc(a_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_rvalid(b_rv), .imem_rdata(b_rd),
        .redirect_valid(b_redir), .redirect_pc(b_rpc),
        .instr_valid(b_valid), .instr_ready(b_rdy),
        .instruccion_r(b_instr), .instr_pc(b_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_rst_n = 1'b0; a_rv = 1'b0; a_rd = '0; a_redir = 1'b0; a_rpc = '0; a_rdy = 1'b0;
        b_rst_n = 1'b0; b_rv = 1'b0; b_rd = '0; b_redir = 1'b0; b_rpc = '0; b_rdy = 1'b0;
        #3;
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_instr", a_instr, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_req", {31'd0, a_req}, 32'd0);

        // ---- streaming with 1-cycle memory, ready high ----
        tick();
        a_rst_n = 1'b1; a_rdy = 1'b1;
        #1;
        chk("s_req0", {31'd0, a_req}, 32'd1);
        chk("s_addr0", a_addr, 32'h0);
        chk("s_valid0", {31'd0, a_valid}, 32'd0);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_1020;
        #1;
        chk("s_req1", {31'd0, a_req}, 32'd0);
        chk("s_valid1", {31'd0, a_valid}, 32'd0);
        tick();
        a_rv = 1'b0;
        #1;
        chk("s_valid2", {31'd0, a_valid}, 32'd1);
        chk("s_pc2", a_pc, 32'h0);
        chk("s_instr2", a_instr, 32'h0000_1020);
        chk("s_addr2", a_addr, 32'h4);
        chk("s_req2", {31'd0, a_req}, 32'd1);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_1022;
        #1;
        chk("s_valid3", {31'd0, a_valid}, 32'd0);
        tick();
        a_rv = 1'b0;
        #1;
        chk("s_valid4", {31'd0, a_valid}, 32'd1);
        chk("s_pc4", a_pc, 32'h4);
        chk("s_instr4", a_instr, 32'h0000_1022);
        chk("s_addr4", a_addr, 32'h8);
        chk("s_req4", {31'd0, a_req}, 32'd1);

        // ---- reset with a request outstanding clears storage ----
        tick();
        a_rst_n = 1'b0;
        #1;
        chk("r_valid", {31'd0, a_valid}, 32'd0);
        chk("r_instr", a_instr, 32'd0);
        chk("r_req", {31'd0, a_req}, 32'd0);

        // ---- backpressure, ready low ----
        tick();
        a_rst_n = 1'b1; a_rdy = 1'b0;
        #1;
        chk("b_addr0", a_addr, 32'h0);
        chk("b_req0", {31'd0, a_req}, 32'd1);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_00A0;
        #1;
        tick();
        a_rv = 1'b0;
        #1;
        chk("b_req2", {31'd0, a_req}, 32'd1);
        chk("b_addr2", a_addr, 32'h4);
        chk("b_pc2", a_pc, 32'h0);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_00A4;
        #1;
        tick();
        a_rv = 1'b0;
        #1;
        chk("b_req_full", {31'd0, a_req}, 32'd0);
        chk("b_head_pc", a_pc, 32'h0);
        chk("b_head_instr", a_instr, 32'h0000_00A0);
        tick();
        a_rdy = 1'b1;
        #1;
        chk("b_req_full2", {31'd0, a_req}, 32'd0);
        chk("b_valid5", {31'd0, a_valid}, 32'd1);
        chk("b_pc5", a_pc, 32'h0);
        chk("b_instr5", a_instr, 32'h0000_00A0);
        tick();
        a_rdy = 1'b0;
        #1;
        chk("b_pc6", a_pc, 32'h4);
        chk("b_instr6", a_instr, 32'h0000_00A4);
        chk("b_req6", {31'd0, a_req}, 32'd1);
        chk("b_addr6", a_addr, 32'h8);

        // ---- redirect while waiting, stale response two cycles later ----
        tick();
        a_redir = 1'b1; a_rpc = 32'h0000_0103;
        #1;
        chk("d_valid_pre", {31'd0, a_valid}, 32'd1);
        chk("d_pc_pre", a_pc, 32'h4);
        tick();
        a_redir = 1'b0; a_rpc = '0;
        #1;
        chk("d_valid_flushed", {31'd0, a_valid}, 32'd0);
        chk("d_req_drop", {31'd0, a_req}, 32'd0);
        tick();
        a_rv = 1'b1; a_rd = 32'hDEAD_BEEF;
        #1;
        chk("d_req_drop2", {31'd0, a_req}, 32'd0);
        tick();
        a_rv = 1'b0;
        #1;
        chk("d_valid_discard", {31'd0, a_valid}, 32'd0);
        chk("d_req_new", {31'd0, a_req}, 32'd1);
        chk("d_addr_new", a_addr, 32'h0000_0100);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_B100;
        #1;
        tick();
        a_rv = 1'b0;
        #1;
        chk("d_valid_new", {31'd0, a_valid}, 32'd1);
        chk("d_pc_new", a_pc, 32'h0000_0100);
        chk("d_instr_new", a_instr, 32'h0000_B100);
        chk("d_addr_next", a_addr, 32'h0000_0104);

        // ---- redirect coinciding with rvalid and a pop ----
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_B104; a_redir = 1'b1; a_rpc = 32'h0000_0200; a_rdy = 1'b1;
        #1;
        chk("c_valid_pre", {31'd0, a_valid}, 32'd1);
        tick();
        a_rv = 1'b0; a_redir = 1'b0; a_rpc = '0; a_rdy = 1'b0;
        #1;
        chk("c_valid_post", {31'd0, a_valid}, 32'd0);
        chk("c_req", {31'd0, a_req}, 32'd1);
        chk("c_addr", a_addr, 32'h0000_0200);
        tick();
        a_rv = 1'b1; a_rd = 32'h0000_C200;
        #1;
        tick();
        a_rv = 1'b0;
        #1;
        chk("c_pc_new", a_pc, 32'h0000_0200);
        chk("c_instr_new", a_instr, 32'h0000_C200);

        // ---- DUT b: PC wrap, reset with entries buffered, late response ----
        tick();
        b_rst_n = 1'b1;
        #1;
        chk("w_addr0", b_addr, 32'hFFFF_FFF8);
        chk("w_req0", {31'd0, b_req}, 32'd1);
        tick();
        b_rv = 1'b1; b_rd = 32'h0000_0011;
        #1;
        tick();
        b_rv = 1'b0;
        #1;
        chk("w_addr1", b_addr, 32'hFFFF_FFFC);
        tick();
        b_rv = 1'b1; b_rd = 32'h0000_0022;
        #1;
        tick();
        b_rv = 1'b0;
        #1;
        chk("w_addr2", b_addr, 32'h0000_0000);
        chk("w_req2", {31'd0, b_req}, 32'd1);
        chk("w_pc_head", b_pc, 32'hFFFF_FFF8);
        chk("w_instr_head", b_instr, 32'h0000_0011);
        tick();
        b_rst_n = 1'b0;
        #1;
        chk("m_valid", {31'd0, b_valid}, 32'd0);
        chk("m_instr", b_instr, 32'd0);
        chk("m_pc", b_pc, 32'd0);
        chk("m_req", {31'd0, b_req}, 32'd0);
        tick();
        b_rst_n = 1'b1; b_rv = 1'b1; b_rd = 32'h0000_0033;
        #1;
        chk("m_addr_rel", b_addr, 32'hFFFF_FFF8);
        chk("m_req_rel", {31'd0, b_req}, 32'd1);
        tick();
        b_rv = 1'b0;
        #1;
        chk("m_late_ignored", {31'd0, b_valid}, 32'd0);
        tick();
        b_rv = 1'b1; b_rd = 32'h0000_0044;
        #1;
        tick();
        b_rv = 1'b0;
        #1;
        chk("m_valid_after", {31'd0, b_valid}, 32'd1);
        chk("m_pc_after", b_pc, 32'hFFFF_FFF8);
        chk("m_instr_after", b_instr, 32'h0000_0044);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
